// File: rtl/a2d_threshold_sampler_if.sv
// Bus bundle for a2d_threshold_sampler.
// Carries the sample stream in, the filtered level out and the event FIFO head
// with its ready/valid handshake.
//   master : sample producer / event consumer (drives sample_*, ev_ready)
//   slave  : the sampler itself (drives dout, dout_x, ev_*, overflow)
interface a2d_threshold_sampler_if #(
  parameter int unsigned CODE_W = 10,
  parameter int unsigned TS_W   = 16
);
  logic              sample_valid;
  logic [CODE_W-1:0] sample_code;
  logic              dout;
  logic              dout_x;
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_rise;
  logic [TS_W-1:0]   ev_ts;
  logic              overflow;

  modport master (
    output sample_valid, sample_code, ev_ready,
    input  dout, dout_x, ev_valid, ev_rise, ev_ts, overflow
  );

  modport slave (
    input  sample_valid, sample_code, ev_ready,
    output dout, dout_x, ev_valid, ev_rise, ev_ts, overflow
  );
endinterface

// File: rtl/a2d_threshold_sampler.sv
// Analog-to-digital threshold sampler.
// Classifies quantized analog samples against VIL/VIH (hysteresis), requires
// FILT consecutive same-class samples to change level, and queues timestamped
// edge events in a DEPTH-entry FIFO.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : slave modport (sample_valid/sample_code in; dout, dout_x, overflow
//          out; ev_valid/ev_ready/ev_rise/ev_ts event FIFO head handshake)
module a2d_threshold_sampler #(
  parameter int unsigned CODE_W   = 10,
  parameter int unsigned VIH_CODE = 700,
  parameter int unsigned VIL_CODE = 300,
  parameter int unsigned FILT     = 3,
  parameter int unsigned TS_W     = 16,
  parameter int unsigned DEPTH    = 4
) (
  input logic                   clk,
  input logic                   rst,
  a2d_threshold_sampler_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CODE_W-1:0] VIH = CODE_W'(VIH_CODE);
  localparam logic [CODE_W-1:0] VIL = CODE_W'(VIL_CODE);
  localparam logic [3:0] FILT_N    = 4'(FILT);
  localparam logic [3:0] FILT_LAST = 4'(FILT - 1);

  typedef enum logic [1:0] {StUnk, StLow, StHigh} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            unk_hi_q;  // class currently being counted while in StUnk
  logic            dout_q;
  logic            dout_x_q;
  logic [TS_W-1:0] ts_q;
  logic            overflow_q;
  logic [AW:0]     wr_ptr_q;
  logic [AW:0]     rd_ptr_q;
  logic [TS_W:0]   mem [DEPTH];  // {rise, ts}

  logic       is_hi;
  logic       is_lo;
  logic [3:0] unk_run;
  logic       push;
  logic       push_rise;
  logic       full;
  logic       empty;
  logic       pop;
  logic       wr_en;

  assign is_hi = (bus.sample_code >= VIH);
  assign is_lo = (bus.sample_code <= VIL);

  // Run length in StUnk if this sample is accepted: continue the run for the
  // same class, otherwise a new class starts over at 1.
  always_comb begin
    unk_run = 4'd1;
    if (cnt_q != 4'd0 && ((is_hi && unk_hi_q) || (is_lo && !unk_hi_q))) begin
      unk_run = cnt_q + 4'd1;
    end
  end

  // Edge qualification; must match the LOW/HIGH transitions in the FSM below.
  always_comb begin
    push      = 1'b0;
    push_rise = 1'b0;
    if (bus.sample_valid && cnt_q == FILT_LAST) begin
      if (state_q == StLow && is_hi) begin
        push      = 1'b1;
        push_rise = 1'b1;
      end else if (state_q == StHigh && is_lo) begin
        push = 1'b1;
      end
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && bus.ev_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StUnk;
      cnt_q      <= 4'd0;
      unk_hi_q   <= 1'b0;
      dout_q     <= 1'b0;
      dout_x_q   <= 1'b1;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      if (bus.sample_valid) begin
        ts_q <= ts_q + 1'b1;
        unique case (state_q)
          StUnk: begin
            if (is_hi || is_lo) begin
              unk_hi_q <= is_hi;
              if (unk_run == FILT_N) begin
                state_q  <= is_hi ? StHigh : StLow;
                dout_q   <= is_hi;
                dout_x_q <= 1'b0;
                cnt_q    <= 4'd0;
              end else begin
                cnt_q <= unk_run;
              end
            end else begin
              cnt_q <= 4'd0;
            end
          end
          StLow: begin
            if (is_hi) begin
              if (cnt_q == FILT_LAST) begin
                state_q <= StHigh;
                dout_q  <= 1'b1;
                cnt_q   <= 4'd0;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end else begin
              cnt_q <= 4'd0;
            end
          end
          StHigh: begin
            if (is_lo) begin
              if (cnt_q == FILT_LAST) begin
                state_q <= StLow;
                dout_q  <= 1'b0;
                cnt_q   <= 4'd0;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end else begin
              cnt_q <= 4'd0;
            end
          end
          default: begin
            state_q <= StUnk;
            cnt_q   <= 4'd0;
          end
        endcase
      end

      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= {push_rise, ts_q};
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_x   = dout_x_q;
  assign bus.overflow = overflow_q;
  assign bus.ev_valid = !empty;
  assign {bus.ev_rise, bus.ev_ts} = mem[rd_ptr_q[AW-1:0]];

endmodule
